issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/iq_pkg.sv | 18 +
 rtl/iq_age_select.sv | 51 +++++
 rtl/issue_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared defaults and entry layout for the out-of-order issue queue.
package iq_pkg;

   localparam int unsigned IQ_DEPTH     = 8;
   localparam int unsigned IQ_TAG_W     = 6;
   localparam int unsigned IQ_PAYLOAD_W = 64;
   localparam int unsigned IQ_NUM_WK    = 2;

   typedef struct packed {
      logic                    valid;
      logic [IQ_PAYLOAD_W-1:0] payload;
      logic [IQ_TAG_W-1:0]     src1_tag;
      logic [IQ_TAG_W-1:0]     src2_tag;
      logic                    src1_rdy;
      logic                    src2_rdy;
   } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Age-matrix oldest-first selector: grants the oldest requesting slot
// regardless of physical slot position.
module iq_age_select #(
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] alloc,
   input  logic [DEPTH-1:0] req,
   output logic [DEPTH-1:0] grant,
   output logic             any_grant
);

   // older[i][j] set means slot i was enqueued before slot j
   logic [DEPTH-1:0] older [DEPTH];
   logic [DEPTH-1:0] blocked;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            older[i] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (alloc[k]) begin
               for (int unsigned j = 0; j < DEPTH; j++) begin
                  older[j][k] <= valid[j];
                  older[k][j] <= 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      blocked = '0;
      grant   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (j != i && req[j] && older[j][i]) begin
               blocked[i] = 1'b1;
            end
         end
         grant[i] = req[i] && !blocked[i];
      end
      any_grant = |req;
   end

endmodule

// File: rtl/issue_queue.sv
// Unified issue queue: any-slot allocation, tag wakeup with same-cycle
// enqueue bypass, oldest-eligible issue and full-queue flush.
module issue_queue
   import iq_pkg::*;
#(
   parameter int unsigned DEPTH     = IQ_DEPTH,
   parameter int unsigned TAG_W     = IQ_TAG_W,
   parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W,
   parameter int unsigned NUM_WK    = IQ_NUM_WK
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enq_valid,
   output logic                      enq_ready,
   input  logic [PAYLOAD_W-1:0]      enq_payload,
   input  logic [TAG_W-1:0]          enq_src1_tag,
   input  logic [TAG_W-1:0]          enq_src2_tag,
   input  logic                      enq_src1_rdy,
   input  logic                      enq_src2_rdy,
   input  logic [NUM_WK-1:0]         wk_valid,
   input  logic [NUM_WK*TAG_W-1:0]   wk_tag,
   output logic                      iss_valid,
   input  logic                      iss_ready,
   output logic [PAYLOAD_W-1:0]      iss_payload,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0]     valid;
   logic [DEPTH-1:0]     rdy1;
   logic [DEPTH-1:0]     rdy2;
   logic [TAG_W-1:0]     tag1    [DEPTH];
   logic [TAG_W-1:0]     tag2    [DEPTH];
   logic [PAYLOAD_W-1:0] payload [DEPTH];
   logic [CW-1:0]        count_q;

   logic [DEPTH-1:0]     wk1;
   logic [DEPTH-1:0]     wk2;
   logic [DEPTH-1:0]     elig;
   logic [DEPTH-1:0]     free_oh;
   logic                 free_found;
   logic [DEPTH-1:0]     alloc;
   logic [DEPTH-1:0]     grant;
   logic [DEPTH-1:0]     valid_next;
   logic                 enq_fire;
   logic                 iss_fire;
   logic                 enq_rdy1;
   logic                 enq_rdy2;

   function automatic logic wk_hit(
      input logic [TAG_W-1:0]        tag,
      input logic [NUM_WK-1:0]       wv,
      input logic [NUM_WK*TAG_W-1:0] wt
   );
      logic hit;
      hit = 1'b0;
      for (int unsigned p = 0; p < NUM_WK; p++) begin
         if (wv[p] && wt[p*TAG_W +: TAG_W] == tag) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   assign enq_ready = (count_q < CW'(DEPTH)) && !flush;
   assign enq_fire  = enq_valid && enq_ready;
   assign iss_fire  = iss_valid && iss_ready;
   assign count     = count_q;

   // Tag 0 is the zero register; a matching broadcast this cycle also counts.
   assign enq_rdy1 = enq_src1_rdy || (enq_src1_tag == '0) ||
                     wk_hit(enq_src1_tag, wk_valid, wk_tag);
   assign enq_rdy2 = enq_src2_rdy || (enq_src2_tag == '0) ||
                     wk_hit(enq_src2_tag, wk_valid, wk_tag);

   always_comb begin
      wk1  = '0;
      wk2  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         wk1[i] = wk_hit(tag1[i], wk_valid, wk_tag);
         wk2[i] = wk_hit(tag2[i], wk_valid, wk_tag);
      end
      elig = valid & rdy1 & rdy2;
   end

   // Allocation only looks at the current valid vector, so a slot freed
   // by this cycle's issue is not handed out until the next cycle.
   always_comb begin
      free_oh    = '0;
      free_found = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!valid[i] && !free_found) begin
            free_oh[i] = 1'b1;
            free_found = 1'b1;
         end
      end
      alloc = enq_fire ? free_oh : '0;
   end

   always_comb begin
      valid_next = (valid & ~(iss_fire ? grant : '0)) | alloc;
      iss_payload = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            iss_payload = iss_payload | payload[i];
         end
      end
   end

   iq_age_select #(
      .DEPTH (DEPTH)
   ) u_age_select (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .valid     (valid),
      .alloc     (alloc),
      .req       (elig),
      .grant     (grant),
      .any_grant (iss_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         valid   <= '0;
         count_q <= '0;
      end else begin
         valid   <= valid_next;
         count_q <= count_q + CW'(enq_fire) - CW'(iss_fire);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (alloc[i]) begin
            payload[i] <= enq_payload;
            tag1[i]    <= enq_src1_tag;
            tag2[i]    <= enq_src2_tag;
            rdy1[i]    <= enq_rdy1;
            rdy2[i]    <= enq_rdy2;
         end else begin
            rdy1[i]    <= rdy1[i] | wk1[i];
            rdy2[i]    <= rdy2[i] | wk2[i];
         end
      end
   end

   a_count_bound : assert property (
      @(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
   a_grant_onehot : assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule
